// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared state encodings, register/word constants and control
//               bundle type for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = c_ST_RUN,
        ST_FLUSH = c_ST_FLUSH,
        ST_HOLD  = c_ST_HOLD
    } state_t;

    localparam logic [4:0]  c_ZERO_REG  = 5'd0;
    localparam logic [31:0] c_ZERO_WORD = 32'h0000_0000;

    typedef struct packed {
        logic pc_jump_en;
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic flush_if_id;
        logic flush_id_ex;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Request/response bundle between the pipeline stages and the
//               hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             jump_en_i;
    logic [31:0]      jump_addr_i;
    logic             hold_req_i;
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic [4:0]       ex_rd_addr_i;
    logic             ex_reg_wen_i;
    logic             ex_is_load_i;

    logic             pc_jump_en_o;
    logic [31:0]      pc_jump_addr_o;
    logic             stall_pc_o;
    logic             stall_if_id_o;
    logic             stall_id_ex_o;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic             hold_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output jump_en_i, jump_addr_i, hold_req_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_addr_i, ex_reg_wen_i, ex_is_load_i,
        input  pc_jump_en_o, pc_jump_addr_o,
               stall_pc_o, stall_if_id_o, stall_id_ex_o,
               flush_if_id_o, flush_id_ex_o,
               hold_timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, hold_req_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_addr_i, ex_reg_wen_i, ex_is_load_i,
        output pc_jump_en_o, pc_jump_addr_o,
               stall_pc_o, stall_if_id_o, stall_id_ex_o,
               flush_if_id_o, flush_id_ex_o,
               hold_timeout_o, stall_cnt_o, flush_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator between decode sources and
//               the load destination sitting in execute.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  wire logic [4:0] i_id_rs1_addr,
    input  wire logic [4:0] i_id_rs2_addr,
    input  wire logic       i_id_rs1_used,
    input  wire logic       i_id_rs2_used,
    input  wire logic [4:0] i_ex_rd_addr,
    input  wire logic       i_ex_reg_wen,
    input  wire logic       i_ex_is_load,
    output logic            o_lu_hazard
);

    logic w_load_writes;
    logic w_rs1_hit;
    logic w_rs2_hit;

    always_comb begin
        // x0 is hardwired, so a load targeting it never produces a dependency
        w_load_writes = i_ex_is_load & i_ex_reg_wen & (i_ex_rd_addr != c_ZERO_REG);
        w_rs1_hit     = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
        w_rs2_hit     = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
        o_lu_hazard   = w_load_writes & (w_rs1_hit | w_rs2_hit);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/flush/redirect controller for the fetch-decode-execute
//               pipeline, with saturating event counters and hold watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int HOLD_MAX     = 1024,
    parameter int CNT_W        = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int                c_FL_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_FL_W-1:0] c_FL_RELOAD = c_FL_W'(FLUSH_CYCLES - 1);
    localparam logic [c_FL_W-1:0] c_FL_ONE    = c_FL_W'(1);
    localparam int                c_HR_W      = $clog2(HOLD_MAX + 1);
    localparam logic [c_HR_W-1:0] c_HR_MAX    = c_HR_W'(HOLD_MAX);
    localparam logic [c_HR_W-1:0] c_HR_ONE    = c_HR_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    logic [c_FL_W-1:0]  r_flush_left;
    logic [c_HR_W-1:0]  r_hold_run;
    logic               r_hold_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_lu_hazard;
    logic               w_hold;
    logic               w_jump;
    logic               w_bubble;
    logic               w_lu_stall;
    logic [c_HR_W-1:0]  w_hold_run_nxt;
    logic [31:0]        w_jump_addr;
    ctrl_t              w_ctrl;

    hazard_detect u_hazard_detect (
        .i_id_rs1_addr (bus.id_rs1_addr_i),
        .i_id_rs2_addr (bus.id_rs2_addr_i),
        .i_id_rs1_used (bus.id_rs1_used_i),
        .i_id_rs2_used (bus.id_rs2_used_i),
        .i_ex_rd_addr  (bus.ex_rd_addr_i),
        .i_ex_reg_wen  (bus.ex_reg_wen_i),
        .i_ex_is_load  (bus.ex_is_load_i),
        .o_lu_hazard   (w_lu_hazard)
    );

    // Priority: hold > jump > load-use. A HOLD state with the request gone
    // behaves exactly like RUN, so only FLUSH needs special treatment here.
    always_comb begin
        w_hold     = bus.hold_req_i;
        w_jump     = bus.jump_en_i & ~w_hold;
        w_bubble   = (r_state == ST_FLUSH) & ~w_hold & ~w_jump;
        w_lu_stall = w_lu_hazard & ~w_hold & ~w_jump & (r_state != ST_FLUSH);

        w_ctrl             = '0;
        w_ctrl.pc_jump_en  = w_jump;
        w_ctrl.stall_pc    = w_hold | w_lu_stall;
        w_ctrl.stall_if_id = w_hold | w_lu_stall;
        w_ctrl.stall_id_ex = w_hold;
        w_ctrl.flush_if_id = w_jump | w_bubble;
        w_ctrl.flush_id_ex = w_jump | w_bubble | w_lu_stall;

        w_jump_addr    = w_jump ? bus.jump_addr_i : c_ZERO_WORD;
        w_hold_run_nxt = (r_hold_run == c_HR_MAX) ? r_hold_run : r_hold_run + c_HR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_flush_left   <= '0;
            r_hold_run     <= '0;
            r_hold_timeout <= 1'b0;
            r_stall_cnt    <= '0;
            r_flush_cnt    <= '0;
        end else begin
            if (w_hold) begin
                // A hold inside FLUSH pauses the bubble count rather than
                // abandoning it
                if (r_state != ST_FLUSH) begin
                    r_state <= ST_HOLD;
                end
            end else if (w_jump) begin
                if (FLUSH_CYCLES > 1) begin
                    r_state      <= ST_FLUSH;
                    r_flush_left <= c_FL_RELOAD;
                end else begin
                    r_state      <= ST_RUN;
                    r_flush_left <= '0;
                end
            end else if (r_state == ST_FLUSH) begin
                if (r_flush_left <= c_FL_ONE) begin
                    r_state      <= ST_RUN;
                    r_flush_left <= '0;
                end else begin
                    r_flush_left <= r_flush_left - c_FL_ONE;
                end
            end else begin
                r_state <= ST_RUN;
            end

            r_hold_run <= w_hold ? w_hold_run_nxt : '0;
            if (w_hold && (w_hold_run_nxt == c_HR_MAX)) begin
                r_hold_timeout <= 1'b1;
            end

            if ((w_hold || w_lu_stall) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_jump && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.pc_jump_en_o   = w_ctrl.pc_jump_en;
    assign bus.pc_jump_addr_o = w_jump_addr;
    assign bus.stall_pc_o     = w_ctrl.stall_pc;
    assign bus.stall_if_id_o  = w_ctrl.stall_if_id;
    assign bus.stall_id_ex_o  = w_ctrl.stall_id_ex;
    assign bus.flush_if_id_o  = w_ctrl.flush_if_id;
    assign bus.flush_id_ex_o  = w_ctrl.flush_id_ex;
    assign bus.hold_timeout_o = r_hold_timeout;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.flush_cnt_o    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench; dut_a uses FLUSH_CYCLES=1,
//               dut_b uses FLUSH_CYCLES=3 with 4-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // {pc_jump_en, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}
    localparam logic [5:0] c_IDLE = 6'b000000;
    localparam logic [5:0] c_JUMP = 6'b100011;
    localparam logic [5:0] c_HOLD = 6'b011100;
    localparam logic [5:0] c_LU   = 6'b011001;
    localparam logic [5:0] c_BUB  = 6'b000011;

    pipe_ctrl_if #(.CNT_W(32)) ifa ();
    pipe_ctrl_if #(.CNT_W(4))  ifb ();

    pipe_ctrl #(.FLUSH_CYCLES(1), .HOLD_MAX(8), .CNT_W(32)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .HOLD_MAX(8), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    typedef struct packed {
        logic       ld;
        logic       wen;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       hit;
    } lu_vec_t;

    function automatic logic [5:0] ctrl_a();
        return {ifa.pc_jump_en_o, ifa.stall_pc_o, ifa.stall_if_id_o,
                ifa.stall_id_ex_o, ifa.flush_if_id_o, ifa.flush_id_ex_o};
    endfunction

    function automatic logic [5:0] ctrl_b();
        return {ifb.pc_jump_en_o, ifb.stall_pc_o, ifb.stall_if_id_o,
                ifb.stall_id_ex_o, ifb.flush_if_id_o, ifb.flush_id_ex_o};
    endfunction

    task automatic idle_a();
        ifa.jump_en_i = 1'b0; ifa.jump_addr_i = 32'h0; ifa.hold_req_i = 1'b0;
        ifa.id_rs1_addr_i = 5'd0; ifa.id_rs2_addr_i = 5'd0;
        ifa.id_rs1_used_i = 1'b0; ifa.id_rs2_used_i = 1'b0;
        ifa.ex_rd_addr_i = 5'd0; ifa.ex_reg_wen_i = 1'b0; ifa.ex_is_load_i = 1'b0;
    endtask

    task automatic idle_b();
        ifb.jump_en_i = 1'b0; ifb.jump_addr_i = 32'h0; ifb.hold_req_i = 1'b0;
        ifb.id_rs1_addr_i = 5'd0; ifb.id_rs2_addr_i = 5'd0;
        ifb.id_rs1_used_i = 1'b0; ifb.id_rs2_used_i = 1'b0;
        ifb.ex_rd_addr_i = 5'd0; ifb.ex_reg_wen_i = 1'b0; ifb.ex_is_load_i = 1'b0;
    endtask

    task automatic lu_b(input logic [4:0] r);
        ifb.ex_is_load_i = 1'b1; ifb.ex_reg_wen_i = 1'b1; ifb.ex_rd_addr_i = r;
        ifb.id_rs1_addr_i = r; ifb.id_rs1_used_i = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_a(); idle_b();
        #2 rst_n = 1'b0;
        #2;
        n_checks++;
        if (ctrl_a() !== c_IDLE) begin n_fail++; $display("FAIL reset ctrl_a: got %b expected %b", ctrl_a(), c_IDLE); end
        n_checks++;
        if (ifa.pc_jump_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset addr_a: got %h expected 0", ifa.pc_jump_addr_o); end
        n_checks++;
        if (ifa.stall_cnt_o !== 32'd0 || ifa.flush_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL reset cnt_a: got stall=%0d flush=%0d expected 0/0", ifa.stall_cnt_o, ifa.flush_cnt_o);
        end
        n_checks++;
        if (ifa.hold_timeout_o !== 1'b0 || ifb.hold_timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL reset timeout: got a=%b b=%b expected 0", ifa.hold_timeout_o, ifb.hold_timeout_o);
        end
        n_checks++;
        if (ctrl_b() !== c_IDLE || ifb.stall_cnt_o !== 4'd0 || ifb.flush_cnt_o !== 4'd0) begin
            n_fail++; $display("FAIL reset b: got ctrl=%b stall=%0d flush=%0d expected 000000/0/0", ctrl_b(), ifb.stall_cnt_o, ifb.flush_cnt_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctrl_a() !== c_IDLE || ifa.stall_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL post_reset a: got ctrl=%b stall=%0d expected 000000/0", ctrl_a(), ifa.stall_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_jump_fc1();
        ifa.jump_en_i = 1'b1; ifa.jump_addr_i = 32'h0000_0040;
        @(negedge clk);
        n_checks++;
        if (ctrl_a() !== c_JUMP) begin n_fail++; $display("FAIL jump1 ctrl: got %b expected %b", ctrl_a(), c_JUMP); end
        n_checks++;
        if (ifa.pc_jump_addr_o !== 32'h0000_0040) begin n_fail++; $display("FAIL jump1 addr: got %h expected 00000040", ifa.pc_jump_addr_o); end
        next_cycle();
        idle_a();
        @(negedge clk);
        n_checks++;
        if (ctrl_a() !== c_IDLE || ifa.pc_jump_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL jump1 after: got ctrl=%b addr=%h expected 000000/0", ctrl_a(), ifa.pc_jump_addr_o);
        end
        n_checks++;
        if (ifa.flush_cnt_o !== 32'd1 || ifa.stall_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL jump1 cnt: got flush=%0d stall=%0d expected 1/0", ifa.flush_cnt_o, ifa.stall_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        lu_vec_t tbl [7];
        tbl[0] = {1'b1, 1'b1, 5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b1};
        tbl[1] = {1'b1, 1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0};
        tbl[2] = {1'b1, 1'b1, 5'd5,  5'd0,  1'b0, 5'd5,  1'b0, 1'b0};
        tbl[3] = {1'b0, 1'b1, 5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b0};
        tbl[4] = {1'b1, 1'b0, 5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b0};
        tbl[5] = {1'b1, 1'b1, 5'd9,  5'd9,  1'b1, 5'd3,  1'b1, 1'b1};
        tbl[6] = {1'b1, 1'b1, 5'd31, 5'd30, 1'b1, 5'd31, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            ifa.ex_is_load_i  = tbl[i].ld;  ifa.ex_reg_wen_i  = tbl[i].wen;
            ifa.ex_rd_addr_i  = tbl[i].rd;
            ifa.id_rs1_addr_i = tbl[i].rs1; ifa.id_rs1_used_i = tbl[i].u1;
            ifa.id_rs2_addr_i = tbl[i].rs2; ifa.id_rs2_used_i = tbl[i].u2;
            @(negedge clk);
            n_checks++;
            if (ctrl_a() !== (tbl[i].hit ? c_LU : c_IDLE)) begin
                n_fail++; $display("FAIL load_use[%0d] ctrl: got %b expected %b", i, ctrl_a(), tbl[i].hit ? c_LU : c_IDLE);
            end
            next_cycle();
        end
        idle_a();
        @(negedge clk);
        n_checks++;
        if (ifa.stall_cnt_o !== 32'd2 || ifa.flush_cnt_o !== 32'd1 || ctrl_a() !== c_IDLE) begin
            n_fail++; $display("FAIL load_use cnt: got stall=%0d flush=%0d ctrl=%b expected 2/1/000000", ifa.stall_cnt_o, ifa.flush_cnt_o, ctrl_a());
        end
        next_cycle();
    endtask

    task automatic test_priority();
        ifa.hold_req_i = 1'b1; ifa.jump_en_i = 1'b1; ifa.jump_addr_i = 32'h0000_0080;
        @(negedge clk);
        n_checks++;
        if (ctrl_a() !== c_HOLD || ifa.pc_jump_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL prio hold_jump: got ctrl=%b addr=%h expected %b/0", ctrl_a(), ifa.pc_jump_addr_o, c_HOLD);
        end
        next_cycle();
        ifa.hold_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctrl_a() !== c_JUMP || ifa.pc_jump_addr_o !== 32'h0000_0080) begin
            n_fail++; $display("FAIL prio release: got ctrl=%b addr=%h expected %b/00000080", ctrl_a(), ifa.pc_jump_addr_o, c_JUMP);
        end
        n_checks++;
        if (ifa.flush_cnt_o !== 32'd1 || ifa.stall_cnt_o !== 32'd3) begin
            n_fail++; $display("FAIL prio cnt_hold: got flush=%0d stall=%0d expected 1/3", ifa.flush_cnt_o, ifa.stall_cnt_o);
        end
        next_cycle();
        ifa.jump_addr_i = 32'h0000_0084;
        ifa.ex_is_load_i = 1'b1; ifa.ex_reg_wen_i = 1'b1; ifa.ex_rd_addr_i = 5'd4;
        ifa.id_rs1_addr_i = 5'd4; ifa.id_rs1_used_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctrl_a() !== c_JUMP || ifa.pc_jump_addr_o !== 32'h0000_0084) begin
            n_fail++; $display("FAIL prio jump_lu: got ctrl=%b addr=%h expected %b/00000084", ctrl_a(), ifa.pc_jump_addr_o, c_JUMP);
        end
        next_cycle();
        idle_a();
        @(negedge clk);
        n_checks++;
        if (ifa.flush_cnt_o !== 32'd3 || ifa.stall_cnt_o !== 32'd3) begin
            n_fail++; $display("FAIL prio cnt_jump_lu: got flush=%0d stall=%0d expected 3/3", ifa.flush_cnt_o, ifa.stall_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_hold_timeout();
        for (int i = 0; i < 7; i++) begin
            ifa.hold_req_i = 1'b1;
            @(negedge clk);
            n_checks++;
            if (ctrl_a() !== c_HOLD) begin n_fail++; $display("FAIL hold7[%0d] ctrl: got %b expected %b", i, ctrl_a(), c_HOLD); end
            next_cycle();
        end
        // Release cycle is evaluated as RUN, so a load-use stall is honoured
        ifa.hold_req_i = 1'b0;
        ifa.ex_is_load_i = 1'b1; ifa.ex_reg_wen_i = 1'b1; ifa.ex_rd_addr_i = 5'd3;
        ifa.id_rs1_addr_i = 5'd3; ifa.id_rs1_used_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctrl_a() !== c_LU || ifa.hold_timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL hold7 release: got ctrl=%b timeout=%b expected %b/0", ctrl_a(), ifa.hold_timeout_o, c_LU);
        end
        next_cycle();
        idle_a();
        for (int i = 0; i < 8; i++) begin
            ifa.hold_req_i = 1'b1;
            @(negedge clk);
            if (i == 7) begin
                n_checks++;
                if (ifa.hold_timeout_o !== 1'b0) begin n_fail++; $display("FAIL hold8 early: got timeout=%b expected 0", ifa.hold_timeout_o); end
            end
            next_cycle();
        end
        ifa.hold_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.hold_timeout_o !== 1'b1) begin n_fail++; $display("FAIL hold8 set: got timeout=%b expected 1", ifa.hold_timeout_o); end
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        n_checks++;
        if (ifa.hold_timeout_o !== 1'b1 || ifa.stall_cnt_o !== 32'd19) begin
            n_fail++; $display("FAIL hold8 sticky: got timeout=%b stall=%0d expected 1/19", ifa.hold_timeout_o, ifa.stall_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_flush_fc3();
        logic [5:0] exp_seq [6];
        ifb.jump_en_i = 1'b1; ifb.jump_addr_i = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_JUMP || ifb.pc_jump_addr_o !== 32'h0000_0100) begin
            n_fail++; $display("FAIL fc3 jump: got ctrl=%b addr=%h expected %b/00000100", ctrl_b(), ifb.pc_jump_addr_o, c_JUMP);
        end
        next_cycle();
        idle_b();
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_BUB || ifb.flush_cnt_o !== 4'd1) begin
            n_fail++; $display("FAIL fc3 bubble2: got ctrl=%b flush=%0d expected %b/1", ctrl_b(), ifb.flush_cnt_o, c_BUB);
        end
        next_cycle();
        ifb.hold_req_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_HOLD) begin n_fail++; $display("FAIL fc3 paused: got %b expected %b", ctrl_b(), c_HOLD); end
        next_cycle();
        ifb.hold_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_BUB) begin n_fail++; $display("FAIL fc3 bubble3: got %b expected %b", ctrl_b(), c_BUB); end
        next_cycle();
        lu_b(5'd7);
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_LU || ifb.stall_cnt_o !== 4'd1) begin
            n_fail++; $display("FAIL fc3 back_in_run: got ctrl=%b stall=%0d expected %b/1", ctrl_b(), ifb.stall_cnt_o, c_LU);
        end
        next_cycle();
        idle_b();
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_IDLE || ifb.stall_cnt_o !== 4'd2) begin
            n_fail++; $display("FAIL fc3 idle: got ctrl=%b stall=%0d expected 000000/2", ctrl_b(), ifb.stall_cnt_o);
        end
        next_cycle();
        // Second jump lands in FLUSH and must restart the bubble count;
        // load-use stays masked while bubbles remain
        exp_seq = '{c_JUMP, c_JUMP, c_BUB, c_BUB, c_LU, c_IDLE};
        for (int i = 0; i < 6; i++) begin
            idle_b();
            if (i < 2) begin
                ifb.jump_en_i = 1'b1; ifb.jump_addr_i = 32'h0000_0200 + 32'(i) * 32'h100;
            end else if (i < 5) begin
                lu_b(5'd12);
            end
            @(negedge clk);
            n_checks++;
            if (ctrl_b() !== exp_seq[i]) begin n_fail++; $display("FAIL fc3 restart[%0d]: got %b expected %b", i, ctrl_b(), exp_seq[i]); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (ifb.flush_cnt_o !== 4'd3 || ifb.stall_cnt_o !== 4'd3) begin
            n_fail++; $display("FAIL fc3 cnt: got flush=%0d stall=%0d expected 3/3", ifb.flush_cnt_o, ifb.stall_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        ifb.hold_req_i = 1'b1;
        for (int i = 0; i < 14; i++) next_cycle();
        ifb.hold_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifb.stall_cnt_o !== 4'hF || ifb.hold_timeout_o !== 1'b1) begin
            n_fail++; $display("FAIL sat stall: got stall=%0d timeout=%b expected 15/1", ifb.stall_cnt_o, ifb.hold_timeout_o);
        end
        next_cycle();
        ifb.jump_en_i = 1'b1; ifb.jump_addr_i = 32'h0000_1000;
        for (int i = 0; i < 13; i++) next_cycle();
        idle_b();
        @(negedge clk);
        n_checks++;
        if (ifb.flush_cnt_o !== 4'hF || ctrl_b() !== c_BUB) begin
            n_fail++; $display("FAIL sat flush: got flush=%0d ctrl=%b expected 15/%b", ifb.flush_cnt_o, ctrl_b(), c_BUB);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_IDLE || ifb.flush_cnt_o !== 4'hF) begin
            n_fail++; $display("FAIL sat drain: got ctrl=%b flush=%0d expected 000000/15", ctrl_b(), ifb.flush_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        ifb.jump_en_i = 1'b1; ifb.jump_addr_i = 32'h0000_0040;
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_JUMP) begin n_fail++; $display("FAIL areset jump: got %b expected %b", ctrl_b(), c_JUMP); end
        next_cycle();
        idle_b();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctrl_b() !== c_IDLE) begin n_fail++; $display("FAIL areset ctrl_b: got %b expected 000000", ctrl_b()); end
        n_checks++;
        if (ifb.stall_cnt_o !== 4'd0 || ifb.flush_cnt_o !== 4'd0 || ifb.hold_timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL areset b regs: got stall=%0d flush=%0d timeout=%b expected 0/0/0", ifb.stall_cnt_o, ifb.flush_cnt_o, ifb.hold_timeout_o);
        end
        n_checks++;
        if (ifa.stall_cnt_o !== 32'd0 || ifa.flush_cnt_o !== 32'd0 || ifa.hold_timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL areset a regs: got stall=%0d flush=%0d timeout=%b expected 0/0/0", ifa.stall_cnt_o, ifa.flush_cnt_o, ifa.hold_timeout_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ctrl_b() !== c_IDLE || ifb.flush_cnt_o !== 4'd0) begin
            n_fail++; $display("FAIL areset residual: got ctrl=%b flush=%0d expected 000000/0", ctrl_b(), ifb.flush_cnt_o);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_jump_fc1();
        test_load_use();
        test_priority();
        test_hold_timeout();
        test_flush_fc3();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
